// File: rtl/pio_fifo.sv
// pio_fifo: synchronous FIFO with registered read data, sticky overflow/underflow flags
// and optional double-capacity join mode (enabled by defining PIO_FIFO_JOIN_EN).
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   join_sel   double-capacity select (only with PIO_FIFO_JOIN_EN); any change flushes
//   push/din   write request and data
//   pull/dout  read request and registered read data (1-cycle latency)
//   full/empty/level  occupancy status, from registered state only
//   overflow/underflow sticky error flags, cleared only by reset
module pio_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
`ifdef PIO_FIFO_JOIN_EN
    input  logic                         join_sel,
`endif
    input  logic                         push,
    input  logic                         pull,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(2*DEPTH):0]     level,
    output logic                         overflow,
    output logic                         underflow
);
`ifdef PIO_FIFO_JOIN_EN
    localparam int CAP_MAX = 2 * DEPTH;
`else
    localparam int CAP_MAX = DEPTH;
`endif
    localparam int AW = $clog2(CAP_MAX);
    localparam int LW = $clog2(2 * DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [CAP_MAX];
    logic [AW-1:0]    r_wr, r_rd;
    logic [LW-1:0]    r_level;
    logic [WIDTH-1:0] r_dout;
    logic             r_ovf, r_unf;
    logic [LW-1:0]    w_cap;
    logic [AW-1:0]    w_last;
    logic             w_flush, w_pull_ok, w_push_ok;

`ifdef PIO_FIFO_JOIN_EN
    // Capacity follows the registered join so full never depends combinationally on inputs.
    logic r_join;
    always_ff @(posedge clk) r_join <= join_sel;
    assign w_flush = join_sel != r_join;
    assign w_cap   = r_join ? LW'(2 * DEPTH) : LW'(DEPTH);
    assign w_last  = r_join ? AW'(2 * DEPTH - 1) : AW'(DEPTH - 1);
`else
    assign w_flush = 1'b0;
    assign w_cap   = LW'(DEPTH);
    assign w_last  = AW'(DEPTH - 1);
`endif

    assign full      = r_level == w_cap;
    assign empty     = r_level == '0;
    assign level     = r_level;
    assign dout      = r_dout;
    assign overflow  = r_ovf;
    assign underflow = r_unf;

    // When full, a simultaneous accepted pull frees the slot the push writes into.
    assign w_pull_ok = pull && !empty;
    assign w_push_ok = push && (!full || w_pull_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok && !reset && !w_flush)
            r_mem[r_wr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            r_dout  <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (w_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push_ok)
                r_wr <= (r_wr == w_last) ? '0 : r_wr + AW'(1);
            if (w_pull_ok) begin
                r_rd   <= (r_rd == w_last) ? '0 : r_rd + AW'(1);
                r_dout <= r_mem[r_rd];
            end
            r_level <= (w_push_ok && !w_pull_ok) ? r_level + LW'(1) :
                       (w_pull_ok && !w_push_ok) ? r_level - LW'(1) : r_level;
            r_ovf   <= r_ovf || (push && !w_push_ok);
            r_unf   <= r_unf || (pull && !w_pull_ok);
        end
    end
endmodule

// File: tb/tb_pio_fifo.sv
// tb_pio_fifo: directed self-checking bench for pio_fifo (WIDTH=32, DEPTH=4).
module tb_pio_fifo;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        push = 1'b0;
    logic        pull = 1'b0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        full, empty, overflow, underflow;
    logic [3:0]  level;
`ifdef PIO_FIFO_JOIN_EN
    logic        join_sel = 1'b0;
`endif
    int n_cmp = 0;
    int n_err = 0;

    pio_fifo #(.WIDTH(32), .DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
`ifdef PIO_FIFO_JOIN_EN
        .join_sel(join_sel),
`endif
        .push(push),
        .pull(pull),
        .din(din),
        .dout(dout),
        .full(full),
        .empty(empty),
        .level(level),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        chk("rst_level", 32'(level), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_dout", dout, 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_unf", 32'(underflow), 0);

        pull = 1'b1;
        step();
        chk("emp_pull_unf", 32'(underflow), 1);
        chk("emp_pull_dout", dout, 0);
        chk("emp_pull_level", 32'(level), 0);
        push = 1'b1; din = 32'h55;
        step();
        chk("emp_pp_level", 32'(level), 1);
        chk("emp_pp_dout", dout, 0);
        push = 1'b0;
        step();
        pull = 1'b0;
        chk("emp_pp_read", dout, 32'h55);
        chk("emp_pp_empty", 32'(empty), 1);

        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_unf", 32'(underflow), 0);

        push = 1'b1;
        din = 32'hA; step();
        din = 32'hB; step();
        din = 32'hC; step();
        push = 1'b0;
        chk("abc_level", 32'(level), 3);
        pull = 1'b1;
        step(); chk("abc_rd0", dout, 32'hA);
        step(); chk("abc_rd1", dout, 32'hB);
        step(); chk("abc_rd2", dout, 32'hC);
        pull = 1'b0;
        chk("abc_empty", 32'(empty), 1);
        chk("abc_level0", 32'(level), 0);
        chk("abc_unf", 32'(underflow), 0);

        push = 1'b1;
        din = 1; step();
        din = 2; step();
        din = 3; step();
        chk("fill3_full", 32'(full), 0);
        din = 4; step();
        chk("fill4_full", 32'(full), 1);
        chk("fill4_ovf", 32'(overflow), 0);
        din = 32'h99; step();
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_level", 32'(level), 4);
        din = 5; pull = 1'b1;
        step();
        push = 1'b0;
        chk("fpp_dout", dout, 1);
        chk("fpp_level", 32'(level), 4);
        chk("fpp_full", 32'(full), 1);
        step(); chk("wrap_rd2", dout, 2);
        step(); chk("wrap_rd3", dout, 3);
        step(); chk("wrap_rd4", dout, 4);
        step(); chk("wrap_rd5", dout, 5);
        pull = 1'b0;
        chk("wrap_empty", 32'(empty), 1);
        chk("wrap_ovf_sticky", 32'(overflow), 1);

        push = 1'b1;
        din = 32'h11; step();
        din = 32'h22; step();
        chk("mid_level", 32'(level), 2);
        din = 32'hEE; reset = 1'b1;
        step();
        push = 1'b0; reset = 1'b0;
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        chk("mid_rst_unf", 32'(underflow), 0);
        pull = 1'b1;
        step();
        pull = 1'b0;
        chk("mid_rst_nostore", 32'(underflow), 1);
        chk("mid_rst_dout2", dout, 0);

`ifdef PIO_FIFO_JOIN_EN
        join_sel = 1'b1; reset = 1'b1;
        step();
        reset = 1'b0;
        push = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            din = 32'(i);
            step();
        end
        chk("join7_full", 32'(full), 0);
        din = 8; step();
        push = 1'b0;
        chk("join8_full", 32'(full), 1);
        chk("join8_level", 32'(level), 8);
        pull = 1'b1;
        for (int i = 0; i < 5; i++) step();
        pull = 1'b0;
        chk("join_rd5", dout, 5);
        chk("join_level3", 32'(level), 3);
        join_sel = 1'b0; push = 1'b1; din = 32'h77;
        step();
        push = 1'b0;
        chk("flush_level", 32'(level), 0);
        chk("flush_empty", 32'(empty), 1);
        chk("flush_dout", dout, 5);
        chk("flush_ovf", 32'(overflow), 0);
        chk("flush_unf", 32'(underflow), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
